// File: rtl/bram_rd_streamer_pkg.sv
// Shared definitions for the BRAM read streamer: FSM encoding and the
// depth of the output buffer that absorbs the RAM read latency.
package bram_rd_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int BUF_DEPTH = 2;
   localparam int BUF_CNT_W = 2;

endpackage

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry FIFO holding {last, data} words returned by the RAM.
// Push and pop may happen in the same cycle; the head is zero while empty.
module bram_rd_skid_fifo
   import bram_rd_streamer_pkg::*;
#(
   parameter int WIDTH = 33
)
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_push,
   input  logic [WIDTH-1:0]     i_push_data,
   input  logic                 i_pop,
   output logic [WIDTH-1:0]     o_head,
   output logic                 o_not_empty,
   output logic [BUF_CNT_W-1:0] o_count
);

   logic [WIDTH-1:0]     r_mem [BUF_DEPTH];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [BUF_CNT_W-1:0] r_count;

   logic                 w_not_empty;
   logic                 w_do_pop;

   assign w_not_empty = (r_count != '0);
   assign w_do_pop    = i_pop & w_not_empty;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + BUF_CNT_W'(i_push) - BUF_CNT_W'(w_do_pop);
      end
   end

   assign o_head      = w_not_empty ? r_mem[r_rd_ptr] : '0;
   assign o_not_empty = w_not_empty;
   assign o_count     = r_count;

endmodule

// File: rtl/bram_rd_streamer.sv
// Burst reader for a 1-cycle-latency BRAM read port, streaming words out as
// valid/ready with a last flag at full rate.
module bram_rd_streamer
   import bram_rd_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   output logic                  ram_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

   state_e                  r_state;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH:0]     r_remaining;
   logic                    r_inflight;
   logic                    r_inflight_last;
   logic                    r_done;

   logic                    w_cmd_fire;
   logic                    w_pop;
   logic                    w_pop_last;
   logic                    w_issue;
   logic                    w_issue_last;
   logic [2:0]              w_outstanding;
   logic [DATA_WIDTH:0]     w_head;
   logic                    w_not_empty;
   logic [BUF_CNT_W-1:0]    w_count;

   // A transfer happens on any cycle where valid and ready are both high;
   // the stream master holds m_data/m_last stable while m_valid & !m_ready.
   assign w_cmd_fire = cmd_valid & (r_state == ST_IDLE);
   assign w_pop      = w_not_empty & m_ready;
   assign w_pop_last = w_pop & w_head[DATA_WIDTH];

   // Words already owed to the buffer after this cycle's pop; never exceed depth.
   assign w_outstanding = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
   assign w_issue       = (r_state == ST_READ) && (r_remaining != '0) &&
                          (w_outstanding < 3'(BUF_DEPTH));
   assign w_issue_last  = w_issue && (r_remaining == LEN_ONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_addr          <= '0;
         r_remaining     <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue_last;
         r_done          <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_fire) begin
                  if (cmd_len != '0) begin
                     r_addr      <= cmd_addr;
                     r_remaining <= cmd_len;
                     r_state     <= ST_READ;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (w_issue) begin
                  r_addr      <= r_addr + ADDR_ONE;
                  r_remaining <= r_remaining - LEN_ONE;
                  if (w_issue_last) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_pop_last) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   bram_rd_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_skid_fifo (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_push      (r_inflight),
      .i_push_data ({r_inflight_last, ram_dout}),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_not_empty (w_not_empty),
      .o_count     (w_count)
   );

   assign cmd_ready = (r_state == ST_IDLE);
   assign ram_en    = w_issue;
   assign ram_addr  = r_addr;
   assign m_valid   = w_not_empty;
   assign m_data    = w_head[DATA_WIDTH-1:0];
   assign m_last    = w_head[DATA_WIDTH];
   assign done      = r_done;
   // The done cycle still counts as busy even though the FSM is back in IDLE.
   assign busy      = (r_state != ST_IDLE) | r_done;

endmodule

// File: tb/tb_bram_rd_streamer.sv
// Directed bench for bram_rd_streamer with a behavioural 1-cycle-latency RAM.
module tb_bram_rd_streamer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        ram_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] mem [1024];
  logic        rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  int n_tests = 0;
  int n_fail  = 0;

  bram_rd_streamer #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM read port model, one cycle latency
  always @(posedge clk) begin
    if (ram_en) ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, ".ram_en"},    64'(ram_en),    64'd0);
    chk({tag, ".ram_addr"},  64'(ram_addr),  64'd0);
    chk({tag, ".m_valid"},   64'(m_valid),   64'd0);
    chk({tag, ".m_data"},    64'(m_data),    64'd0);
    chk({tag, ".m_last"},    64'(m_last),    64'd0);
    chk({tag, ".busy"},      64'(busy),      64'd0);
    chk({tag, ".done"},      64'(done),      64'd0);
  endtask

  task automatic check_cycle(input string tag, input logic en, input logic [9:0] addr,
                             input logic v, input logic [31:0] data, input logic last,
                             input logic dn, input logic rdy);
    chk({tag, ".ram_en"}, 64'(ram_en), 64'(en));
    if (en) chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(addr));
    chk({tag, ".m_valid"}, 64'(m_valid), 64'(v));
    if (v) begin
      chk({tag, ".m_data"}, 64'(m_data), 64'(data));
      chk({tag, ".m_last"}, 64'(m_last), 64'(last));
    end
    chk({tag, ".done"}, 64'(done), 64'(dn));
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(rdy));
  endtask

  int          issued;
  int          popped;
  int          done_seen;
  logic        pop;
  logic        exp_en;
  logic        prev_stall;
  logic        prev_last;
  logic [31:0] prev_data;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 256);
    repeat (2) tick();
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    tick();

    // basic burst: addr 5, len 4, full rate
    m_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 10'd5; cmd_len = 11'd4;
    #1 chk("basic.cmd_ready", 64'(cmd_ready), 64'd1);
    tick(); cmd_valid = 1'b0; #1;
    check_cycle("basic.c1", 1'b1, 10'd5, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("basic.c1.busy", 64'(busy), 64'd1);
    tick(); #1; check_cycle("basic.c2", 1'b1, 10'd6, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("basic.c3", 1'b1, 10'd7, 1'b1, 32'h105, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("basic.c4", 1'b1, 10'd8, 1'b1, 32'h106, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("basic.c5", 1'b0, 10'd0, 1'b1, 32'h107, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("basic.c6", 1'b0, 10'd0, 1'b1, 32'h108, 1'b1, 1'b0, 1'b0);
    tick(); #1; check_cycle("basic.c7", 1'b0, 10'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1);
    chk("basic.c7.busy", 64'(busy), 64'd1);
    tick(); #1; check_cycle("basic.c8", 1'b0, 10'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1);
    chk("basic.c8.busy", 64'(busy), 64'd0);

    // address wrap: 1022, 1023, 0, 1
    tick();
    cmd_valid = 1'b1; cmd_addr = 10'd1022; cmd_len = 11'd4;
    tick(); cmd_valid = 1'b0; #1;
    check_cycle("wrap.c1", 1'b1, 10'd1022, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("wrap.c2", 1'b1, 10'd1023, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("wrap.c3", 1'b1, 10'd0,    1'b1, 32'h4fe, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("wrap.c4", 1'b1, 10'd1,    1'b1, 32'h4ff, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("wrap.c5", 1'b0, 10'd0,    1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("wrap.c6", 1'b0, 10'd0,    1'b1, 32'h101, 1'b1, 1'b0, 1'b0);
    tick(); #1; check_cycle("wrap.c7", 1'b0, 10'd0,    1'b0, 32'h0,   1'b0, 1'b1, 1'b1);

    // zero length: no RAM access, done next cycle
    tick();
    cmd_valid = 1'b1; cmd_addr = 10'd7; cmd_len = 11'd0;
    #1 chk("zero.cmd_ready", 64'(cmd_ready), 64'd1);
    tick(); cmd_valid = 1'b0; #1;
    check_cycle("zero.c1", 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("zero.c1.busy", 64'(busy), 64'd1);
    tick(); #1;
    check_cycle("zero.c2", 1'b0, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("zero.c2.busy", 64'(busy), 64'd0);

    // backpressure: len 8 from addr 20, ready pattern 1,0,0,1,0,1 repeating
    tick();
    m_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 10'd20; cmd_len = 11'd8;
    tick(); cmd_valid = 1'b0;
    issued = 0; popped = 0; done_seen = 0; prev_stall = 1'b0;
    prev_last = 1'b0; prev_data = '0;
    for (int c = 0; c < 40; c++) begin
      m_ready = rdy_pat[c % 6];
      #1;
      pop = m_valid & m_ready;
      if (prev_stall) begin
        chk("bp.hold_valid", 64'(m_valid), 64'd1);
        chk("bp.hold_data",  64'(m_data),  64'(prev_data));
        chk("bp.hold_last",  64'(m_last),  64'(prev_last));
      end
      exp_en = (issued < 8) && ((issued - popped - int'(pop)) < 2);
      chk("bp.ram_en", 64'(ram_en), 64'(exp_en));
      if (ram_en) begin
        chk("bp.ram_addr", 64'(ram_addr), 64'(20 + issued));
        issued++;
      end
      if (pop) begin
        chk("bp.data", 64'(m_data), 64'(32'h114 + popped));
        chk("bp.last", 64'(m_last), 64'(popped == 7));
        popped++;
      end
      if (done) done_seen++;
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      tick();
    end
    chk("bp.issued",    64'(issued),    64'd8);
    chk("bp.popped",    64'(popped),    64'd8);
    chk("bp.done_seen", 64'(done_seen), 64'd1);

    // reset mid-burst after the third beat
    m_ready = 1'b1; cmd_valid = 1'b1; cmd_addr = 10'd100; cmd_len = 11'd16;
    tick(); cmd_valid = 1'b0; #1;
    check_cycle("rst.c1", 1'b1, 10'd100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick(); #1; check_cycle("rst.c3", 1'b1, 10'd102, 1'b1, 32'h164, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("rst.c4", 1'b1, 10'd103, 1'b1, 32'h165, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("rst.c5", 1'b1, 10'd104, 1'b1, 32'h166, 1'b0, 1'b0, 1'b0);
    tick(); rst_n = 1'b0; #1;
    chk("rst.c6.busy", 64'(busy), 64'd1);
    tick(); rst_n = 1'b1; #1;
    check_reset("rst.c7");
    tick(); #1;
    chk("rst.c8.m_valid", 64'(m_valid), 64'd0);
    chk("rst.c8.done",    64'(done),    64'd0);
    chk("rst.c8.ram_en",  64'(ram_en),  64'd0);
    chk("rst.c8.busy",    64'(busy),    64'd0);
    cmd_valid = 1'b1; cmd_addr = 10'd0; cmd_len = 11'd2;
    #1 chk("rst.c8.cmd_ready", 64'(cmd_ready), 64'd1);
    tick(); cmd_valid = 1'b0; #1;
    check_cycle("rst.n1", 1'b1, 10'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("rst.n2", 1'b1, 10'd1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("rst.n3", 1'b0, 10'd0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("rst.n4", 1'b0, 10'd0, 1'b1, 32'h101, 1'b1, 1'b0, 1'b0);
    tick(); #1; check_cycle("rst.n5", 1'b0, 10'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1);

    // back-to-back: len 3 at 40, then len 1 at 60 held until accepted
    tick();
    cmd_valid = 1'b1; cmd_addr = 10'd40; cmd_len = 11'd3;
    tick(); cmd_addr = 10'd60; cmd_len = 11'd1; #1;
    check_cycle("b2b.c1", 1'b1, 10'd40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c2", 1'b1, 10'd41, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c3", 1'b1, 10'd42, 1'b1, 32'h128, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c4", 1'b0, 10'd0,  1'b1, 32'h129, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c5", 1'b0, 10'd0,  1'b1, 32'h12a, 1'b1, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c6", 1'b0, 10'd0,  1'b0, 32'h0,   1'b0, 1'b1, 1'b1);
    tick(); cmd_valid = 1'b0; #1;
    check_cycle("b2b.c7", 1'b1, 10'd60, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c8",  1'b0, 10'd0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c9",  1'b0, 10'd0, 1'b1, 32'h13c, 1'b1, 1'b0, 1'b0);
    tick(); #1; check_cycle("b2b.c10", 1'b0, 10'd0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
